dco_tune_ctrl: RTL
==================

DCO_TUNE_CTRL -- requirements
Module: dco_tune_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, default 32, tuning word width; TICK_DIV, default 4, sys_clk cycles per slew step (>=1); SETTLE_CYC, default 8, settle cycles after target reached (>=1); RESET_WORD, default 0, tuning word after reset.
REQ-002 SHALL have ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  new target request.
- req_ready  output  1  controller can accept a request.
- req_word  input  WIDTH  requested target tuning word (unsigned).
- max_step  input  WIDTH  slew limit per step; 0 = jump in one step; sampled with the request.
- abort  input  1  cancel the slew/settle in progress.
- tuning_word  output  WIDTH  registered word driving dco_nco tuning_word.
- busy  output  1  high in SLEW or SETTLE.
- locked  output  1  target reached and settled.
- done  output  1  one-cycle pulse on completion.

Function
REQ-003 SHALL implement states IDLE, SLEW, SETTLE, DONE.
REQ-004 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge where req_valid&&req_ready, capturing req_word and max_step into internal registers.
REQ-005 On acceptance SHALL clear locked, clear the tick counter, and go to SLEW; if req_word equals tuning_word, go to DONE instead.
REQ-006 In SLEW the tick counter SHALL count 0..TICK_DIV-1; on the cycle it equals TICK_DIV-1 it wraps to 0 and one step is applied, so the first step is TICK_DIV cycles after acceptance.
REQ-007 Each step SHALL move tuning_word toward target by min(max_step,|target-tuning_word|), or by the full difference when max_step=0; unsigned compare/subtract, no modular wrap, never overshoot.
REQ-008 When a step makes tuning_word equal to target, the next state SHALL be SETTLE with the settle counter cleared.
REQ-009 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter DONE.
REQ-010 DONE SHALL last one cycle with done=1 and locked set to 1, then return to IDLE.
REQ-011 locked SHALL stay 1 until the next accepted request or reset.
REQ-012 tuning_word SHALL change only on a step or reset and SHALL be held constant in IDLE, SETTLE and DONE.
REQ-013 abort=1 in SLEW or SETTLE SHALL return to IDLE on the next edge, hold the current tuning_word, keep locked=0, and suppress done.
REQ-014 abort in IDLE or DONE SHALL be ignored; req_valid and abort together in IDLE SHALL accept the request.
REQ-015 abort asserted on the same edge as a SLEW step SHALL take priority: no step applied.
REQ-016 busy SHALL equal (state==SLEW || state==SETTLE).
REQ-017 req_word and max_step changes while not in IDLE SHALL have no effect.

Reset
REQ-018 rst=1 SHALL asynchronously force state IDLE, tuning_word=RESET_WORD, tick and settle counters 0, target register RESET_WORD, locked=0, done=0, busy=0; req_ready=1.
REQ-019 rst asserted mid-SLEW or mid-SETTLE SHALL abandon the operation with no done pulse; operation resumes on the first edge after release.

Verification (WIDTH=32, TICK_DIV=4, SETTLE_CYC=8, RESET_WORD=0)
REQ-020 Reset: hold rst 3 cycles, assert mid-cycle -> tuning_word=0, req_ready=1, busy=0, locked=0, done=0 immediately.
REQ-021 Jump: req_word=42949673, max_step=0 -> tuning_word=42949673 4 cycles after accept, 8 SETTLE cycles, done pulse for one cycle, locked=1, req_ready=1 next cycle.
REQ-022 Up-slew: from 42949673, req_word=85899346, max_step=10000000 -> steps 52949673, 62949673, 72949673, 82949673, 85899346 every 4 cycles, then settle, done; never exceeds target.
REQ-023 Down-slew: from 85899346, req_word=42949673, max_step=10000000 -> 75899346 ... 45899346, 42949673; never below target.
REQ-024 Abort: during up-slew assert abort one cycle after second step -> tuning_word held at 62949673, no done, locked=0, req_ready=1 next cycle; abort coincident with step edge -> no step applied.
REQ-025 Equal request and reset mid-op: req_word equal to tuning_word -> done one cycle after accept, no SETTLE; rst during SLEW -> tuning_word=0 at once, no done.

Source files
------------

// File: rtl/dco_tune_ctrl.sv
// Slew-limited tuning-word controller for a DCO/NCO: accepts a target word, walks
// the output toward it in bounded steps on a tick cadence, settles, then reports lock.
module dco_tune_ctrl #(
  parameter int               WIDTH      = 32,
  parameter int               TICK_DIV   = 4,
  parameter int               SETTLE_CYC = 8,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_word,
  input  logic [WIDTH-1:0] max_step,
  input  logic             abort,
  output logic [WIDTH-1:0] tuning_word,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and req_word/max_step are sampled only then.

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SLEW   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] max_step_q;
  logic [TW-1:0]    tick;
  logic [SW-1:0]    settle;

  logic             step_up;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] step_amt;
  logic [WIDTH-1:0] next_word;
  logic             step_reaches;

  assign state_dbg = state;

  // Step size is clamped to the remaining distance, so the add/subtract never wraps.
  always_comb begin
    step_up      = (target > tuning_word);
    diff         = step_up ? (target - tuning_word) : (tuning_word - target);
    step_amt     = ((max_step_q == '0) || (max_step_q >= diff)) ? diff : max_step_q;
    next_word    = step_up ? (tuning_word + step_amt) : (tuning_word - step_amt);
    step_reaches = (step_amt == diff);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tuning_word <= RESET_WORD;
      target      <= RESET_WORD;
      max_step_q  <= '0;
      tick        <= '0;
      settle      <= '0;
      locked      <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            target     <= req_word;
            max_step_q <= max_step;
            tick       <= '0;
            req_ready  <= 1'b0;
            if (req_word == tuning_word) begin
              state  <= S_DONE;
              done   <= 1'b1;
              locked <= 1'b1;
            end else begin
              state  <= S_SLEW;
              busy   <= 1'b1;
              locked <= 1'b0;
            end
          end
        end
        S_SLEW: begin
          // Abort wins over a step landing on the same edge.
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else if (tick == TICK_LAST) begin
            tick        <= '0;
            tuning_word <= next_word;
            if (step_reaches) begin
              state  <= S_SETTLE;
              settle <= '0;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else if (settle == SETTLE_LAST) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            locked <= 1'b1;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
